// File: rtl/trade_pkt_pkg.sv
// trade_pkt_pkg: trade packet field positions, packetizer state enum and packing helper
// Build option: define PKT_CHECKSUM_EN to fill the trailer with an XOR checksum (default: zero trailer).
package trade_pkt_pkg;

    localparam int PKT_W        = 128;
    localparam int TRADE_ID_MSB = 127;
    localparam int TRADE_ID_LSB = 112;
    localparam int PRICE_MSB    = 111;
    localparam int PRICE_LSB    = 80;
    localparam int QTY_MSB      = 79;
    localparam int QTY_LSB      = 64;
    localparam int SEQ_MSB      = 63;
    localparam int SEQ_LSB      = 32;
    localparam int TRAIL_MSB    = 31;
    localparam int TRAIL_LSB    = 0;

    typedef enum logic {IDLE, SEND} state_t;

    function automatic logic [PKT_W-1:0] pack(
        input logic [15:0] tid,
        input logic [31:0] prc,
        input logic [15:0] qty,
        input logic [31:0] seq
    );
        logic [PKT_W-1:0] p;
        p = '0;
        p[TRADE_ID_MSB:TRADE_ID_LSB] = tid;
        p[PRICE_MSB:PRICE_LSB]       = prc;
        p[QTY_MSB:QTY_LSB]           = qty;
        p[SEQ_MSB:SEQ_LSB]           = seq;
`ifdef PKT_CHECKSUM_EN
        p[TRAIL_MSB:TRAIL_LSB]       = p[127:96] ^ p[95:64] ^ p[63:32];
`else
        p[TRAIL_MSB:TRAIL_LSB]       = 32'h0;
`endif
        return p;
    endfunction

endpackage

// File: rtl/trade_packetizer_beat_serializer.sv
// beat_serializer: 128-bit shift register emitting MSB-first beats with valid/ready/last
// Ports: clk, rstn (async active-low); i_load/i_data load a packet and reset the beat count;
//        i_valid/i_ready are the beat handshake; o_data current beat, o_last final beat,
//        o_last_hs pulses on the handshake of the final beat.
module beat_serializer
    import trade_pkt_pkg::*;
#(
    parameter int BEAT_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_load,
    input  logic [PKT_W-1:0]  i_data,
    input  logic              i_valid,
    input  logic              i_ready,
    output logic [BEAT_W-1:0] o_data,
    output logic              o_last,
    output logic              o_last_hs
);
    localparam int N  = PKT_W / BEAT_W;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [PKT_W-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic             w_hs;

    assign w_hs      = i_valid && i_ready;
    assign o_data    = r_shift[PKT_W-1 -: BEAT_W];
    assign o_last    = i_valid && (r_cnt == LAST);
    assign o_last_hs = w_hs && o_last;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_shift <= i_data;
            r_cnt   <= '0;
        end else if (w_hs) begin
            r_shift <= r_shift << BEAT_W;
            r_cnt   <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/trade_packetizer.sv
// trade_packetizer: packs trade records into 128-bit packets, emits full word and MSB-first beat stream
// Ports: clk, rstn (async active-low); tradeID/price/quantity/fieldsValid/fieldsReady record input;
//        packetOut/packetOutValid full-word loopback output; outData/outValid/outReady/outLast
//        beat stream; seqNum sequence number of the next packet.
// Build option: PKT_CHECKSUM_EN selects an XOR checksum trailer instead of zero.
module trade_packetizer
    import trade_pkt_pkg::*;
#(
    parameter int          BEAT_W   = 8,
    parameter logic [31:0] SEQ_INIT = 32'h0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [15:0]       tradeID,
    input  logic [31:0]       price,
    input  logic [15:0]       quantity,
    input  logic              fieldsValid,
    output logic              fieldsReady,
    output logic [PKT_W-1:0]  packetOut,
    output logic              packetOutValid,
    output logic [BEAT_W-1:0] outData,
    output logic              outValid,
    input  logic              outReady,
    output logic              outLast,
    output logic [31:0]       seqNum
);
    state_t           r_state, w_next;
    logic [PKT_W-1:0] r_packet, w_packed;
    logic             r_pkt_valid;
    logic [31:0]      r_seq;
    logic             w_accept, w_last_hs;

    assign w_packed       = pack(tradeID, price, quantity, r_seq);
    assign w_accept       = (r_state == IDLE) && fieldsValid;
    assign packetOut      = r_packet;
    assign packetOutValid = r_pkt_valid;
    assign seqNum         = r_seq;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_packet    <= '0;
            r_pkt_valid <= 1'b0;
            r_seq       <= SEQ_INIT;
        end else begin
            r_state     <= w_next;
            r_pkt_valid <= w_accept;
            if (w_accept) begin
                r_packet <= w_packed;
                r_seq    <= r_seq + 32'd1;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        fieldsReady = 1'b0;
        outValid    = 1'b0;
        case (r_state)
            IDLE: begin
                fieldsReady = 1'b1;
                w_next      = fieldsValid ? SEND : IDLE;
            end
            SEND: begin
                outValid = 1'b1;
                w_next   = w_last_hs ? IDLE : SEND;
            end
            default: w_next = IDLE;
        endcase
    end

    beat_serializer #(.BEAT_W(BEAT_W)) u_ser (
        .clk      (clk),
        .rstn     (rstn),
        .i_load   (w_accept),
        .i_data   (w_packed),
        .i_valid  (outValid),
        .i_ready  (outReady),
        .o_data   (outData),
        .o_last   (outLast),
        .o_last_hs(w_last_hs)
    );

endmodule

// File: tb/tb_trade_packetizer.sv
// tb_trade_packetizer: scoreboard bench for trade_packetizer (directed records, backpressure, wrap, reset abort)
module tb_trade_packetizer;
    localparam int BEAT_W = 8;
    localparam int N      = 128 / BEAT_W;

`ifdef PKT_CHECKSUM_EN
    localparam logic [31:0] TA = 32'hACDBDEEF;
    localparam logic [31:0] TB = 32'hA8C95465;
    localparam logic [31:0] TC = 32'hFFFE8002;
    localparam logic [31:0] TD = 32'h33331112;
`else
    localparam logic [31:0] TA = 32'h0;
    localparam logic [31:0] TB = 32'h0;
    localparam logic [31:0] TC = 32'h0;
    localparam logic [31:0] TD = 32'h0;
`endif
    localparam logic [127:0] PA = {64'h1234DEADBEEF0042, 32'h0, TA};
    localparam logic [127:0] PB = {64'hABCD010203045566, 32'h1, TB};
    localparam logic [127:0] PC = {64'hFFFF800000010000, 32'h2, TC};
    localparam logic [127:0] PD = {64'h1111222222223333, 32'h3, TD};

    logic              clk = 1'b0;
    logic              rstn;
    logic [15:0]       tradeID;
    logic [31:0]       price;
    logic [15:0]       quantity;
    logic              fieldsValid;
    logic              fieldsReady;
    logic [127:0]      packetOut;
    logic              packetOutValid;
    logic [BEAT_W-1:0] outData;
    logic              outValid;
    logic              outReady;
    logic              outLast;
    logic [31:0]       seqNum;

    logic              w_fieldsReady;
    logic [127:0]      w_packetOut;
    logic              w_packetOutValid;
    logic [BEAT_W-1:0] w_outData;
    logic              w_outValid;
    logic              w_outLast;
    logic [31:0]       w_seqNum;

    int tests = 0;
    int fails = 0;
    int hs_cnt = 0;
    logic [127:0]    exp_pkt_q[$];
    logic [BEAT_W:0] exp_beat_q[$];
    logic            stall_prev = 1'b0;
    logic [BEAT_W-1:0] prev_data;
    logic            prev_last;

    always #5 clk = ~clk;

    trade_packetizer #(.BEAT_W(BEAT_W), .SEQ_INIT(32'h0)) dut (
        .clk(clk), .rstn(rstn), .tradeID(tradeID), .price(price), .quantity(quantity),
        .fieldsValid(fieldsValid), .fieldsReady(fieldsReady), .packetOut(packetOut),
        .packetOutValid(packetOutValid), .outData(outData), .outValid(outValid),
        .outReady(outReady), .outLast(outLast), .seqNum(seqNum)
    );

    trade_packetizer #(.BEAT_W(BEAT_W), .SEQ_INIT(32'hFFFFFFFF)) dut_w (
        .clk(clk), .rstn(rstn), .tradeID(tradeID), .price(price), .quantity(quantity),
        .fieldsValid(fieldsValid), .fieldsReady(w_fieldsReady), .packetOut(w_packetOut),
        .packetOutValid(w_packetOutValid), .outData(w_outData), .outValid(w_outValid),
        .outReady(outReady), .outLast(w_outLast), .seqNum(w_seqNum)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [BEAT_W:0] e;
        if (packetOutValid) begin
            if (exp_pkt_q.size() == 0) check("pkt_unexpected", 1, 0);
            else check("packetOut", packetOut, exp_pkt_q.pop_front());
        end
        if (stall_prev && rstn) begin
            check("hold_valid", outValid, 1);
            check("hold_data", outData, prev_data);
            check("hold_last", outLast, prev_last);
        end
        if (outValid && outReady) begin
            hs_cnt++;
            if (exp_beat_q.size() == 0) check("beat_unexpected", 1, 0);
            else begin
                e = exp_beat_q.pop_front();
                check("beat_data", outData, e[BEAT_W-1:0]);
                check("beat_last", outLast, e[BEAT_W]);
            end
        end
        stall_prev = outValid && !outReady;
        prev_data  = outData;
        prev_last  = outLast;
    end

    task automatic send(input logic [15:0] tid, input logic [31:0] prc, input logic [15:0] qty,
                        input logic [127:0] exp, input logic [31:0] exp_wseq);
        int t = 0;
        while (!fieldsReady && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check("ready_timeout", fieldsReady, 1);
        exp_pkt_q.push_back(exp);
        for (int i = 0; i < N; i++) exp_beat_q.push_back({(i == N - 1), exp[127 - i*BEAT_W -: BEAT_W]});
        tradeID = tid; price = prc; quantity = qty; fieldsValid = 1'b1;
        @(posedge clk); #1;
        fieldsValid = 1'b0;
        tradeID = ~tid; price = ~prc; quantity = ~qty;
        check("busy_not_ready", fieldsReady, 0);
        check("first_beat_valid", outValid, 1);
        check("wrap_seq_field", w_packetOut[63:32], exp_wseq);
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_beat_q.size() != 0 || !fieldsReady) && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_timeout", (exp_beat_q.size() == 0) && fieldsReady, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int t;
        rstn = 1'b0; tradeID = '0; price = '0; quantity = '0; fieldsValid = 1'b0; outReady = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_fieldsReady", fieldsReady, 1);
        check("rst_packetOut", packetOut, 0);
        check("rst_packetOutValid", packetOutValid, 0);
        check("rst_outData", outData, 0);
        check("rst_outValid", outValid, 0);
        check("rst_outLast", outLast, 0);
        check("rst_seqNum", seqNum, 0);
        check("rst_w_seqNum", w_seqNum, 32'hFFFFFFFF);
        rstn = 1'b1;
        @(posedge clk); #1;

        send(16'h1234, 32'hDEADBEEF, 16'h0042, PA, 32'hFFFFFFFF);
        drain();
        check("seq_after_A", seqNum, 1);
        check("packetOut_hold", packetOut, PA);

        send(16'hABCD, 32'h01020304, 16'h5566, PB, 32'h0);
        drain();
        check("seq_after_B", seqNum, 2);
        check("w_seq_after_wrap", w_seqNum, 1);

        send(16'hFFFF, 32'h80000001, 16'h0000, PC, 32'h1);
        for (int k = 0; k < 200 && exp_beat_q.size() != 0; k++) begin
            outReady = (k % 4 == 0) || (k % 4 == 3);
            @(posedge clk); #1;
            if (exp_beat_q.size() != 0) check("bp_not_ready", fieldsReady, 0);
        end
        outReady = 1'b1;
        drain();
        check("seq_after_C", seqNum, 3);

        base = hs_cnt;
        send(16'h1111, 32'h22222222, 16'h3333, PD, 32'h2);
        t = 0;
        while (hs_cnt < base + 5 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check("abort_wait_timeout", hs_cnt >= base + 5, 1);
        rstn = 1'b0;
        #1;
        check("abort_outValid", outValid, 0);
        check("abort_outLast", outLast, 0);
        check("abort_seqNum", seqNum, 0);
        check("abort_w_seqNum", w_seqNum, 32'hFFFFFFFF);
        check("abort_fieldsReady", fieldsReady, 1);
        exp_beat_q.delete();
        #2;
        rstn = 1'b1;
        @(posedge clk); #1;

        send(16'h1234, 32'hDEADBEEF, 16'h0042, PA, 32'hFFFFFFFF);
        drain();
        check("seq_after_restart", seqNum, 1);
        check("pkt_queue_empty", exp_pkt_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
